// File: rtl/image_sep_pkg.sv
// image_sep_pkg: shared definitions for the pixel separation datapath.
//   - default frame geometry and pixel width
//   - foreground value forced on matching pixels
//   - frame controller state encoding
//   - counter width helper that stays legal for single-entry ranges
package image_sep_pkg;

   localparam int unsigned DEF_WIDTH = 8;
   localparam int unsigned DEF_COLS  = 640;
   localparam int unsigned DEF_ROWS  = 480;

   // Foreground value for a matching pixel at the default width.
   localparam logic [DEF_WIDTH-1:0] FG_MATCH = '1;

   // Frame controller states.
   typedef logic [1:0] state_t;
   localparam state_t StIdle  = 2'd0;
   localparam state_t StRun   = 2'd1;
   localparam state_t StDrain = 2'd2;
   localparam state_t StDone  = 2'd3;

   // Width of a counter that must hold 0..n-1. Never returns 0, so a
   // single-column or single-row frame still gets a 1-bit counter.
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/pixel_sep.sv
// pixel_sep: combinational per-pixel separation stage.
//   a     in   WIDTH  frame A pixel
//   b     in   WIDTH  frame B pixel
//   fg    out  WIDTH  all-ones when a equals b, otherwise a
//   bg    out  WIDTH  b passed through
//   match out  1      full-width equality of a and b
module pixel_sep
   import image_sep_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] fg,
   output logic [WIDTH-1:0] bg,
   output logic             match
);

   always_comb begin
      match = (a == b);
      fg    = match ? {WIDTH{1'b1}} : a;
      bg    = b;
   end

endmodule

// File: rtl/image_sep_frame_ctrl.sv
// image_sep_frame_ctrl: frame-level controller for the pixel separation
// datapath. Accepts (A, B) pixel pairs in raster order, runs each pair
// through pixel_sep, and holds one registered result with backpressure.
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   start      in   single-cycle frame start (honoured only when idle)
//   in_valid   in   pixel pair present
//   in_ready   out  pair accepted on in_valid & in_ready
//   in_a/in_b  in   frame A / frame B pixel
//   out_valid  out  result present
//   out_ready  in   downstream accepts result
//   out_fg     out  separated foreground pixel
//   out_bg     out  frame B pixel
//   out_last   out  result is the final pixel of the frame
//   busy       out  frame in progress (run or drain)
//   done       out  one-cycle pulse after the last result is taken
//   match_cnt  out  matching pixels in the current/last frame
module image_sep_frame_ctrl
   import image_sep_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH,
   parameter int unsigned COLS  = DEF_COLS,
   parameter int unsigned ROWS  = DEF_ROWS
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            start,
   input  logic                            in_valid,
   output logic                            in_ready,
   input  logic [WIDTH-1:0]                in_a,
   input  logic [WIDTH-1:0]                in_b,
   output logic                            out_valid,
   input  logic                            out_ready,
   output logic [WIDTH-1:0]                out_fg,
   output logic [WIDTH-1:0]                out_bg,
   output logic                            out_last,
   output logic                            busy,
   output logic                            done,
   output logic [$clog2(COLS*ROWS+1)-1:0]  match_cnt
);

   localparam int unsigned CW = cnt_width(COLS);
   localparam int unsigned RW = cnt_width(ROWS);
   // Sized to COLS*ROWS so a frame of all-matching pixels cannot wrap.
   localparam int unsigned MW = $clog2(COLS * ROWS + 1);

   localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);

   state_t            state_q, state_d;
   logic [CW-1:0]     col_q, col_d;
   logic [RW-1:0]     row_q, row_d;
   logic [MW-1:0]     match_q, match_d;
   logic              valid_q, valid_d;
   logic [WIDTH-1:0]  fg_q, fg_d;
   logic [WIDTH-1:0]  bg_q, bg_d;
   logic              last_q, last_d;

   logic [WIDTH-1:0]  sep_fg;
   logic [WIDTH-1:0]  sep_bg;
   logic              sep_match;

   logic              accept;
   logic              out_hs;
   logic              last_pix;

   pixel_sep #(
      .WIDTH (WIDTH)
   ) u_sep (
      .a     (in_a),
      .b     (in_b),
      .fg    (sep_fg),
      .bg    (sep_bg),
      .match (sep_match)
   );

   // Single output register: a new pair is taken only when the slot is
   // empty or being emptied in this same cycle.
   assign in_ready = (state_q == StRun) & (~valid_q | out_ready);
   assign accept   = in_valid & in_ready;
   assign out_hs   = valid_q & out_ready;
   assign last_pix = (col_q == COL_LAST) & (row_q == ROW_LAST);

   always_comb begin
      state_d = state_q;
      col_d   = col_q;
      row_d   = row_q;
      match_d = match_q;
      valid_d = valid_q;
      fg_d    = fg_q;
      bg_d    = bg_q;
      last_d  = last_q;

      // Drain first; a same-cycle accept below overrides it, so a
      // back-to-back stream sees no bubble.
      if (out_hs) begin
         valid_d = 1'b0;
      end

      case (state_q)
         StIdle: begin
            if (start) begin
               state_d = StRun;
               col_d   = '0;
               row_d   = '0;
               match_d = '0;
            end
         end

         StRun: begin
            if (accept) begin
               valid_d = 1'b1;
               fg_d    = sep_fg;
               bg_d    = sep_bg;
               last_d  = last_pix;
               if (sep_match) begin
                  match_d = match_q + MW'(1);
               end
               if (col_q == COL_LAST) begin
                  col_d = '0;
                  row_d = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
               end else begin
                  col_d = col_q + CW'(1);
               end
               if (last_pix) begin
                  state_d = StDrain;
               end
            end
         end

         StDrain: begin
            if (out_hs && last_q) begin
               state_d = StDone;
            end
         end

         StDone: begin
            state_d = StIdle;
         end

         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         col_q   <= '0;
         row_q   <= '0;
         match_q <= '0;
         valid_q <= 1'b0;
         fg_q    <= '0;
         bg_q    <= '0;
         last_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         col_q   <= col_d;
         row_q   <= row_d;
         match_q <= match_d;
         valid_q <= valid_d;
         fg_q    <= fg_d;
         bg_q    <= bg_d;
         last_q  <= last_d;
      end
   end

   assign out_valid = valid_q;
   assign out_fg    = fg_q;
   assign out_bg    = bg_q;
   assign out_last  = last_q;
   assign match_cnt = match_q;
   assign busy      = (state_q == StRun) | (state_q == StDrain);
   assign done      = (state_q == StDone);

endmodule

// File: tb/tb_image_sep_frame_ctrl.sv
// Directed bench for image_sep_frame_ctrl with a 4x2 frame of 8-bit pixels.
module tb_image_sep_frame_ctrl;

   localparam int W  = 8;
   localparam int C  = 4;
   localparam int R  = 2;
   localparam int MW = $clog2(C * R + 1);

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  in_a;
   logic [W-1:0]  in_b;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  out_fg;
   logic [W-1:0]  out_bg;
   logic          out_last;
   logic          busy;
   logic          done;
   logic [MW-1:0] match_cnt;

   image_sep_frame_ctrl #(
      .WIDTH (W),
      .COLS  (C),
      .ROWS  (R)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_fg    (out_fg),
      .out_bg    (out_bg),
      .out_last  (out_last),
      .busy      (busy),
      .done      (done),
      .match_cnt (match_cnt)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Stimulus for one frame and what the frame driver observed.
   logic [W-1:0] va [8];
   logic [W-1:0] vb [8];
   logic [W-1:0] exp_fg [8];
   logic [15:0]  rdy_pat;
   int           start_pix;
   bit           start_in_done;

   logic [W-1:0] got_fg [16];
   logic [W-1:0] got_bg [16];
   logic         got_last [16];
   int           got_n, done_cnt, done_cyc, last_hs, hold_bad, rdy_bad;
   logic         busy_at_done;

   // Runs start + 8 pairs; samples at negedge+1, away from the active edge.
   task automatic drive_frame();
      int   i;
      bit   stall_prev;
      logic [W-1:0] pfg, pbg;
      logic plast;
      got_n = 0; done_cnt = 0; done_cyc = -1; last_hs = -1;
      hold_bad = 0; rdy_bad = 0; busy_at_done = 1'bx;
      stall_prev = 0; pfg = '0; pbg = '0; plast = 1'b0;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      i = 0;
      for (int cyc = 0; cyc < 200; cyc++) begin
         out_ready = rdy_pat[cyc % 16];
         in_valid  = (i < 8);
         in_a      = va[(i < 8) ? i : 7];
         in_b      = vb[(i < 8) ? i : 7];
         start     = (start_pix >= 0) && (i == start_pix);
         #1;
         if (stall_prev && (out_fg !== pfg || out_bg !== pbg || out_last !== plast))
            hold_bad++;
         if (out_valid && !out_ready && in_ready) rdy_bad++;
         if (done === 1'b1) begin
            done_cnt++;
            if (done_cyc < 0) begin
               done_cyc     = cyc;
               busy_at_done = busy;
            end
            if (start_in_done) start = 1'b1;
         end
         if (out_valid && out_ready) begin
            if (got_n < 16) begin
               got_fg[got_n]   = out_fg;
               got_bg[got_n]   = out_bg;
               got_last[got_n] = out_last;
            end
            got_n++;
            last_hs = cyc;
         end
         if (in_valid && in_ready) i++;
         stall_prev = out_valid && !out_ready;
         pfg = out_fg; pbg = out_bg; plast = out_last;
         if (done_cyc >= 0 && cyc >= done_cyc + 4) break;
         @(negedge clk);
      end
      in_valid = 1'b0; start = 1'b0; out_ready = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;
      #2;
      checks++;
      if ({in_ready, out_valid, out_fg, out_bg, out_last, busy, done, match_cnt} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got rdy=%b ov=%b fg=%h bg=%h last=%b busy=%b done=%b mc=%0d required all 0",
                  in_ready, out_valid, out_fg, out_bg, out_last, busy, done, match_cnt);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      in_valid = 1'b1; in_a = 8'h10; in_b = 8'h10; out_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         #1;
         checks++;
         if (in_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_no_start: cycle %0d got in_ready=%b out_valid=%b busy=%b required 0/0/0",
                     k, in_ready, out_valid, busy);
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic test_full_frame();
      va = '{8'h10, 8'h21, 8'h32, 8'h43, 8'h54, 8'h65, 8'h76, 8'h87};
      vb = '{8'h10, 8'h22, 8'h33, 8'h43, 8'h55, 8'h66, 8'h77, 8'h87};
      exp_fg = '{8'hFF, 8'h21, 8'h32, 8'hFF, 8'h54, 8'h65, 8'h76, 8'hFF};
      rdy_pat = 16'hFFFF; start_pix = -1; start_in_done = 0;
      drive_frame();
      checks++;
      if (got_n !== 8) begin
         errors++; $display("FAIL full_count: got %0d results required 8", got_n);
      end
      for (int k = 0; k < 8; k++) begin
         checks++;
         if (got_fg[k] !== exp_fg[k] || got_bg[k] !== vb[k] || got_last[k] !== (k == 7)) begin
            errors++;
            $display("FAIL full_pix%0d: got fg=%h bg=%h last=%b required fg=%h bg=%h last=%b",
                     k, got_fg[k], got_bg[k], got_last[k], exp_fg[k], vb[k], k == 7);
         end
      end
      checks++;
      if (match_cnt !== 4'd3) begin
         errors++; $display("FAIL full_match_cnt: got %0d required 3", match_cnt);
      end
      checks++;
      if (done_cnt !== 1 || done_cyc - last_hs !== 1 || done_cyc !== 9) begin
         errors++;
         $display("FAIL full_done_timing: got pulses=%0d done_cyc=%0d last_hs=%0d required 1/9/8",
                  done_cnt, done_cyc, last_hs);
      end
      checks++;
      if (busy_at_done !== 1'b0) begin
         errors++; $display("FAIL full_busy_at_done: got %b required 0", busy_at_done);
      end
   endtask

   task automatic test_backpressure();
      va = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
      vb = '{8'h00, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      exp_fg = '{8'h01, 8'h02, 8'hFF, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
      rdy_pat = 16'h9999; start_pix = -1; start_in_done = 0;
      drive_frame();
      checks++;
      if (got_n !== 8) begin
         errors++; $display("FAIL bp_count: got %0d results required 8", got_n);
      end
      for (int k = 0; k < 8; k++) begin
         checks++;
         if (got_fg[k] !== exp_fg[k] || got_bg[k] !== vb[k]) begin
            errors++;
            $display("FAIL bp_order%0d: got fg=%h bg=%h required fg=%h bg=%h",
                     k, got_fg[k], got_bg[k], exp_fg[k], vb[k]);
         end
      end
      checks++;
      if (hold_bad !== 0 || rdy_bad !== 0) begin
         errors++;
         $display("FAIL bp_stall: got hold_changes=%0d ready_while_stalled=%0d required 0/0",
                  hold_bad, rdy_bad);
      end
      checks++;
      if (match_cnt !== 4'd1 || done_cnt !== 1) begin
         errors++;
         $display("FAIL bp_match_done: got mc=%0d done=%0d required 1/1", match_cnt, done_cnt);
      end
   endtask

   task automatic test_boundary();
      va = '{8'hFF, 8'hFF, 8'h00, 8'h01, 8'h80, 8'h7F, 8'hFE, 8'h00};
      vb = '{8'hFF, 8'hFE, 8'h01, 8'h00, 8'h81, 8'h7E, 8'hFF, 8'h00};
      exp_fg = '{8'hFF, 8'hFF, 8'h00, 8'h01, 8'h80, 8'h7F, 8'hFE, 8'hFF};
      rdy_pat = 16'hFFFF; start_pix = -1; start_in_done = 0;
      drive_frame();
      for (int k = 0; k < 8; k++) begin
         checks++;
         if (got_fg[k] !== exp_fg[k] || got_bg[k] !== vb[k]) begin
            errors++;
            $display("FAIL bound_pix%0d: got fg=%h bg=%h required fg=%h bg=%h",
                     k, got_fg[k], got_bg[k], exp_fg[k], vb[k]);
         end
      end
      checks++;
      if (match_cnt !== 4'd2) begin
         errors++; $display("FAIL bound_match_cnt: got %0d required 2", match_cnt);
      end
   endtask

   task automatic test_start_busy();
      va = '{8'h10, 8'h21, 8'h32, 8'h43, 8'h54, 8'h65, 8'h76, 8'h87};
      vb = '{8'h10, 8'h22, 8'h33, 8'h43, 8'h55, 8'h66, 8'h77, 8'h87};
      rdy_pat = 16'hFFFF; start_pix = 5; start_in_done = 1;
      drive_frame();
      checks++;
      if (got_n !== 8 || got_last[7] !== 1'b1 || done_cnt !== 1) begin
         errors++;
         $display("FAIL busy_start: got results=%0d last7=%b done=%0d required 8/1/1",
                  got_n, got_last[7], done_cnt);
      end
      #1;
      checks++;
      if (busy !== 1'b0 || match_cnt !== 4'd3) begin
         errors++;
         $display("FAIL start_in_done: got busy=%b mc=%0d required 0/3", busy, match_cnt);
      end
      start_pix = -1; start_in_done = 0;
   endtask

   task automatic test_reset_mid();
      va = '{8'h11, 8'h22, 8'h30, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      vb = '{8'h11, 8'h22, 8'h31, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      out_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         in_valid = 1'b1; in_a = va[k]; in_b = vb[k];
         @(negedge clk);
      end
      in_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({in_ready, out_valid, out_fg, out_bg, out_last, busy, done, match_cnt} !== '0) begin
         errors++;
         $display("FAIL reset_mid_outputs: got rdy=%b ov=%b fg=%h bg=%h last=%b busy=%b done=%b mc=%0d required all 0",
                  in_ready, out_valid, out_fg, out_bg, out_last, busy, done, match_cnt);
      end
      done_cnt = 0;
      repeat (2) begin
         @(negedge clk);
         if (done !== 1'b0) done_cnt++;
      end
      rst_n = 1'b1;
      repeat (3) begin
         @(negedge clk);
         #1;
         if (done !== 1'b0) done_cnt++;
      end
      checks++;
      if (done_cnt !== 0) begin
         errors++; $display("FAIL reset_mid_no_done: got %0d done pulses required 0", done_cnt);
      end
      va = '{8'h10, 8'h21, 8'h32, 8'h43, 8'h54, 8'h65, 8'h76, 8'h87};
      vb = '{8'h10, 8'h22, 8'h33, 8'h43, 8'h55, 8'h66, 8'h77, 8'h87};
      rdy_pat = 16'hFFFF; start_pix = -1; start_in_done = 0;
      drive_frame();
      checks++;
      if (got_n !== 8 || match_cnt !== 4'd3 || done_cnt !== 1) begin
         errors++;
         $display("FAIL reset_mid_rerun: got results=%0d mc=%0d done=%0d required 8/3/1",
                  got_n, match_cnt, done_cnt);
      end
   endtask

   initial begin
      test_reset();
      test_full_frame();
      test_backpressure();
      test_boundary();
      test_start_busy();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
